// File: rtl/program_sequencer.sv
// Plays a stored program of 18-bit instruction words into the CPU instruction port,
// emitting one registered enviar pulse per word with a fixed inter-issue gap.
module program_sequencer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [17:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    output logic [17:0]       instrucao,
    output logic              enviar,
    output logic [ADDR_W-1:0] pc,
    output logic              running,
    output logic              done
);

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [17:0]       mem_reg [DEPTH];
    logic [17:0]       instrucao_reg;
    logic              enviar_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              running_reg;
    logic              done_reg;
    logic [ADDR_W:0]   len_reg;
    logic [CNT_W-1:0]  gap_cnt_reg;

    logic              loadable;
    logic              mem_we;
    logic [ADDR_W:0]   len_clamped;
    logic              last_word;

    assign loadable    = (state_reg == S_IDLE) || (state_reg == S_DONE);
    assign mem_we      = load_we && loadable && !abort;
    assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign last_word   = ({1'b0, pc_reg} == (len_reg - LEN_ONE));

    // Program store is cleared by reset, so it lives in registers rather than RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (mem_we) begin
            mem_reg[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            instrucao_reg <= '0;
            enviar_reg    <= 1'b0;
            pc_reg        <= '0;
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
            len_reg       <= '0;
            gap_cnt_reg   <= '0;
        end else begin
            enviar_reg <= 1'b0;
            if (abort) begin
                state_reg   <= S_IDLE;
                running_reg <= 1'b0;
                done_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        // A start in the same edge as a write still fetches the new
                        // word, because the fetch happens one cycle later.
                        if (start) begin
                            if (len_clamped == '0) begin
                                state_reg   <= S_DONE;
                                running_reg <= 1'b0;
                                done_reg    <= 1'b1;
                            end else begin
                                len_reg     <= len_clamped;
                                pc_reg      <= '0;
                                state_reg   <= S_FETCH;
                                running_reg <= 1'b1;
                                done_reg    <= 1'b0;
                            end
                        end else if (load_we && state_reg == S_DONE) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        instrucao_reg <= mem_reg[pc_reg];
                        state_reg     <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (!hold) begin
                            enviar_reg  <= 1'b1;
                            gap_cnt_reg <= GAP_LOAD;
                            state_reg   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_reg == '0) begin
                            if (last_word) begin
                                state_reg   <= S_DONE;
                                running_reg <= 1'b0;
                                done_reg    <= 1'b1;
                            end else begin
                                pc_reg    <= pc_reg + 1'b1;
                                state_reg <= S_FETCH;
                            end
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg   <= S_IDLE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign instrucao = instrucao_reg;
    assign enviar    = enviar_reg;
    assign pc        = pc_reg;
    assign running   = running_reg;
    assign done      = done_reg;

endmodule
